// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC and next-PC selection, I-cache miss handling,
// and the IF/ID pipeline register that feeds decode.
module fetch_stage #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                   i_clk,
    input  logic                   i_arst,
    input  logic                   i_stall_if,
    input  logic                   i_stall_id,
    input  logic                   i_flush_id,
    input  logic                   i_trap_redirect,
    input  logic [ADDR_WIDTH-1:0]  i_trap_vector,
    input  logic                   i_branch_mispred,
    input  logic [ADDR_WIDTH-1:0]  i_pc_target_ex,
    input  logic                   i_btb_hit,
    input  logic [ADDR_WIDTH-1:0]  i_btb_target,
    input  logic [1:0]             i_btb_way,
    input  logic                   i_pred_taken,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic                   i_instr_valid,
    output logic [ADDR_WIDTH-1:0]  o_fetch_addr,
    output logic                   o_fetch_req,
    output logic [INSTR_WIDTH-1:0] o_instruction,
    output logic [ADDR_WIDTH-1:0]  o_pc,
    output logic [ADDR_WIDTH-1:0]  o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]  o_pc_target_addr_pred,
    output logic [1:0]             o_btb_way,
    output logic                   o_branch_pred_taken,
    output logic                   o_valid
);

    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~ADDR_WIDTH'(3);

    typedef enum logic [1:0] {StFetch, StMissWait, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  pend_q, pend_d;

    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  id_pc_q, id_pc_d;
    logic [ADDR_WIDTH-1:0]  id_pc4_q, id_pc4_d;
    logic [ADDR_WIDTH-1:0]  id_pred_q, id_pred_d;
    logic [1:0]             id_way_q, id_way_d;
    logic                   id_taken_q, id_taken_d;
    logic                   id_valid_q, id_valid_d;

    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic                   predict_taken;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  pred_next;
    logic                   capture;

    always_comb begin
        redirect        = i_trap_redirect | i_branch_mispred;
        redirect_target = (i_trap_redirect ? i_trap_vector : i_pc_target_ex) & AlignMask;
        predict_taken   = i_btb_hit & i_pred_taken;
        pc_plus4        = pc_q + ADDR_WIDTH'(4);
        pred_next       = predict_taken ? (i_btb_target & AlignMask) : pc_plus4;

        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        capture = 1'b0;

        unique case (state_q)
            StFetch, StMissWait: begin
                if (redirect) begin
                    // An outstanding fill must complete before the PC can move.
                    if (state_q == StMissWait && !i_instr_valid) begin
                        pend_d  = redirect_target;
                        state_d = StDrain;
                    end else begin
                        pc_d    = redirect_target;
                        state_d = StFetch;
                    end
                end else if (i_instr_valid) begin
                    state_d = StFetch;
                    if (!i_stall_if) begin
                        capture = 1'b1;
                        pc_d    = pred_next;
                    end
                end else if (!i_stall_if) begin
                    state_d = StMissWait;
                end
            end
            StDrain: begin
                if (i_instr_valid) begin
                    pc_d    = redirect ? redirect_target : pend_q;
                    state_d = StFetch;
                end else if (redirect) begin
                    pend_d = redirect_target;
                end
            end
            default: state_d = StFetch;
        endcase

        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_pred_d  = id_pred_q;
        id_way_d   = id_way_q;
        id_taken_d = id_taken_q;
        id_valid_d = id_valid_q;
        if (i_flush_id || (!i_stall_id && !capture)) begin
            instr_d    = NOP_INSTR;
            id_pc_d    = '0;
            id_pc4_d   = '0;
            id_pred_d  = '0;
            id_way_d   = '0;
            id_taken_d = 1'b0;
            id_valid_d = 1'b0;
        end else if (!i_stall_id) begin
            instr_d    = i_instr;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_pred_d  = pred_next;
            id_way_d   = i_btb_way;
            id_taken_d = predict_taken;
            id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_q    <= StFetch;
            pc_q       <= RESET_PC;
            pend_q     <= '0;
            instr_q    <= NOP_INSTR;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            id_pred_q  <= '0;
            id_way_q   <= '0;
            id_taken_q <= 1'b0;
            id_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            id_pred_q  <= id_pred_d;
            id_way_q   <= id_way_d;
            id_taken_q <= id_taken_d;
            id_valid_q <= id_valid_d;
        end
    end

    assign o_fetch_addr          = pc_q;
    assign o_fetch_req           = ~i_arst;
    assign o_instruction         = instr_q;
    assign o_pc                  = id_pc_q;
    assign o_pc_plus4            = id_pc4_q;
    assign o_pc_target_addr_pred = id_pred_q;
    assign o_btb_way             = id_way_q;
    assign o_branch_pred_taken   = id_taken_q;
    assign o_valid               = id_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a
// transaction-level reference model.
module tb_fetch_stage;

    localparam logic [63:0] RST = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        arst, stall_if, stall_id, flush_id, trap, mispred;
    logic        btb_hit, pred_taken, instr_valid;
    logic [63:0] trap_vec, pc_ex, btb_tgt;
    logic [1:0]  btb_way;
    logic [31:0] instr;
    logic [63:0] f_addr, o_pc, o_pc4, o_pred;
    logic        f_req, o_taken, o_valid;
    logic [31:0] o_instr;
    logic [1:0]  o_way;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .i_clk                 (clk),
        .i_arst                (arst),
        .i_stall_if            (stall_if),
        .i_stall_id            (stall_id),
        .i_flush_id            (flush_id),
        .i_trap_redirect       (trap),
        .i_trap_vector         (trap_vec),
        .i_branch_mispred      (mispred),
        .i_pc_target_ex        (pc_ex),
        .i_btb_hit             (btb_hit),
        .i_btb_target          (btb_tgt),
        .i_btb_way             (btb_way),
        .i_pred_taken          (pred_taken),
        .i_instr               (instr),
        .i_instr_valid         (instr_valid),
        .o_fetch_addr          (f_addr),
        .o_fetch_req           (f_req),
        .o_instruction         (o_instr),
        .o_pc                  (o_pc),
        .o_pc_plus4            (o_pc4),
        .o_pc_target_addr_pred (o_pred),
        .o_btb_way             (o_way),
        .o_branch_pred_taken   (o_taken),
        .o_valid               (o_valid)
    );

    // Reference model: PC, whether a fill is outstanding, whether a redirect is
    // parked behind that fill, and the decode-side view of the last fetch.
    logic [63:0] m_pc, m_parked_pc, m_opc, m_opc4, m_pred;
    bit          m_fill_open, m_parked;
    logic [31:0] m_instr;
    logic [1:0]  m_way;
    bit          m_taken, m_valid;

    task automatic model_step();
        logic [63:0] tgt, seq_pc;
        bit          redir, took, hit_taken;
        if (arst) begin
            m_pc = RST; m_parked_pc = '0; m_fill_open = 0; m_parked = 0;
            m_instr = NOP; m_opc = '0; m_opc4 = '0; m_pred = '0;
            m_way = '0; m_taken = 0; m_valid = 0;
            return;
        end
        redir     = trap || mispred;
        tgt       = trap ? trap_vec : pc_ex;
        tgt[1:0]  = 2'b00;
        hit_taken = btb_hit && pred_taken;
        seq_pc    = m_pc + 64'd4;
        took      = 0;
        if (m_parked) begin
            if (instr_valid) begin
                m_pc = redir ? tgt : m_parked_pc;
                m_parked = 0;
            end else if (redir) begin
                m_parked_pc = tgt;
            end
        end else if (redir) begin
            if (m_fill_open && !instr_valid) begin
                m_parked_pc = tgt;
                m_parked = 1;
            end else begin
                m_pc = tgt;
            end
            m_fill_open = 0;
        end else if (instr_valid) begin
            m_fill_open = 0;
            took = !stall_if;
        end else if (!stall_if) begin
            m_fill_open = 1;
        end

        if (flush_id || (!stall_id && !took)) begin
            m_instr = NOP; m_opc = '0; m_opc4 = '0; m_pred = '0;
            m_way = '0; m_taken = 0; m_valid = 0;
        end else if (!stall_id) begin
            m_instr = instr; m_opc = m_pc; m_opc4 = seq_pc;
            m_pred  = hit_taken ? {btb_tgt[63:2], 2'b00} : seq_pc;
            m_way   = btb_way; m_taken = hit_taken; m_valid = 1;
        end
        if (took) m_pc = hit_taken ? {btb_tgt[63:2], 2'b00} : seq_pc;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_if = 0; stall_id = 0; flush_id = 0; trap = 0; mispred = 0;
        trap_vec = '0; pc_ex = '0; btb_hit = 0; btb_tgt = '0; btb_way = '0;
        pred_taken = 0; instr = $urandom; instr_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        arst = 1;
        tick();
        tick();
        arst = 0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        arst = 1;
        tick();
        tick();
        n_vec++; if (f_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", f_req); end
        n_vec++; if (f_addr !== RST) begin n_err++; $display("FAIL reset_addr got %h want %h", f_addr, RST); end
        n_vec++; if ({o_instr, o_valid, o_pc, o_pc4, o_pred, o_way, o_taken} !== {NOP, 1'b0, 192'd0, 2'd0, 1'b0}) begin
            n_err++; $display("FAIL reset_ifid got instr=%h v=%b pc=%h pc4=%h pred=%h way=%0d tk=%b want bubble",
                              o_instr, o_valid, o_pc, o_pc4, o_pred, o_way, o_taken);
        end
        arst = 0;
        #1;
        n_vec++; if (f_req !== 1'b1) begin n_err++; $display("FAIL reset_release_req got %b want 1", f_req); end
    endtask

    task automatic test_seq_hits();
        logic [31:0] w;
        do_reset();
        instr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            w = $urandom;
            instr = w;
            n_vec++; if (i == 0 && o_valid !== 1'b0) begin n_err++; $display("FAIL seq_latency got valid=%b want 0", o_valid); end
            tick();
            n_vec++; if (o_pc !== RST + 64'(4 * i)) begin n_err++; $display("FAIL seq_pc%0d got %h want %h", i, o_pc, RST + 64'(4 * i)); end
            n_vec++; if ({o_valid, o_instr, o_pc4, o_taken} !== {1'b1, w, RST + 64'(4 * i + 4), 1'b0}) begin
                n_err++; $display("FAIL seq_fields%0d got v=%b instr=%h pc4=%h tk=%b want v=1 instr=%h pc4=%h tk=0",
                                  i, o_valid, o_instr, o_pc4, o_taken, w, RST + 64'(4 * i + 4));
            end
            n_vec++; if (o_pred !== RST + 64'(4 * i + 4)) begin n_err++; $display("FAIL seq_pred%0d got %h want %h", i, o_pred, RST + 64'(4 * i + 4)); end
        end
        n_vec++; if (f_addr !== RST + 64'd12) begin n_err++; $display("FAIL seq_addr got %h want %h", f_addr, RST + 64'd12); end
    endtask

    task automatic test_btb();
        do_reset();
        instr_valid = 1;
        tick();
        btb_hit = 1; pred_taken = 1; btb_tgt = 64'h8000_0100; btb_way = 2'd2;
        tick();
        n_vec++; if (f_addr !== 64'h8000_0100) begin n_err++; $display("FAIL btb_addr got %h want 80000100", f_addr); end
        n_vec++; if ({o_pc, o_pred, o_taken, o_way} !== {64'h8000_0004, 64'h8000_0100, 1'b1, 2'd2}) begin
            n_err++; $display("FAIL btb_ifid got pc=%h pred=%h tk=%b way=%0d want pc=80000004 pred=80000100 tk=1 way=2",
                              o_pc, o_pred, o_taken, o_way);
        end
        pred_taken = 0;
        tick();
        n_vec++; if ({f_addr, o_pred, o_taken} !== {64'h8000_0104, 64'h8000_0104, 1'b0}) begin
            n_err++; $display("FAIL btb_not_taken got addr=%h pred=%h tk=%b want 80000104 80000104 0", f_addr, o_pred, o_taken);
        end
    endtask

    task automatic test_miss();
        logic [31:0] w;
        do_reset();
        instr_valid = 1;
        tick();
        tick();
        instr_valid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_vec++; if ({f_addr, o_valid} !== {64'h8000_0008, 1'b0}) begin
                n_err++; $display("FAIL miss_hold%0d got addr=%h v=%b want 80000008 0", i, f_addr, o_valid);
            end
        end
        w = $urandom;
        instr = w; instr_valid = 1;
        tick();
        n_vec++; if ({o_pc, o_valid, o_instr, f_addr} !== {64'h8000_0008, 1'b1, w, 64'h8000_000c}) begin
            n_err++; $display("FAIL miss_fill got pc=%h v=%b instr=%h addr=%h want 80000008 1 %h 8000000c",
                              o_pc, o_valid, o_instr, f_addr, w);
        end
    endtask

    task automatic test_drain();
        do_reset();
        instr_valid = 1;
        tick();
        tick();
        instr_valid = 0;
        tick();
        mispred = 1; pc_ex = 64'h8000_0203;
        tick();
        mispred = 0;
        n_vec++; if ({f_addr, o_valid} !== {64'h8000_0008, 1'b0}) begin
            n_err++; $display("FAIL drain_enter got addr=%h v=%b want 80000008 0", f_addr, o_valid);
        end
        tick();
        n_vec++; if (f_addr !== 64'h8000_0008) begin n_err++; $display("FAIL drain_hold got %h want 80000008", f_addr); end
        instr_valid = 1;
        tick();
        n_vec++; if ({f_addr, o_valid} !== {64'h8000_0200, 1'b0}) begin
            n_err++; $display("FAIL drain_discard got addr=%h v=%b want 80000200 0", f_addr, o_valid);
        end
        tick();
        n_vec++; if ({o_pc, o_valid} !== {64'h8000_0200, 1'b1}) begin
            n_err++; $display("FAIL drain_resume got pc=%h v=%b want 80000200 1", o_pc, o_valid);
        end
    endtask

    task automatic test_trap_flush();
        do_reset();
        instr_valid = 1;
        tick();
        trap = 1; trap_vec = 64'h8000_1000; mispred = 1; pc_ex = 64'h8000_0200; flush_id = 1;
        tick();
        trap = 0; mispred = 0; flush_id = 0;
        n_vec++; if (f_addr !== 64'h8000_1000) begin n_err++; $display("FAIL trap_addr got %h want 80001000", f_addr); end
        n_vec++; if ({o_valid, o_instr, o_pc} !== {1'b0, NOP, 64'd0}) begin
            n_err++; $display("FAIL trap_bubble got v=%b instr=%h pc=%h want 0 %h 0", o_valid, o_instr, o_pc, NOP);
        end
    endtask

    task automatic test_stall_and_reset_mid_miss();
        logic [31:0] held;
        do_reset();
        instr_valid = 1;
        tick();
        tick();
        held = o_instr;
        stall_if = 1; stall_id = 1;
        for (int i = 0; i < 2; i++) begin
            instr = $urandom;
            tick();
            n_vec++; if ({o_pc, o_valid, o_instr, f_addr} !== {64'h8000_0004, 1'b1, held, 64'h8000_0008}) begin
                n_err++; $display("FAIL stall%0d got pc=%h v=%b instr=%h addr=%h want 80000004 1 %h 80000008",
                                  i, o_pc, o_valid, o_instr, f_addr, held);
            end
        end
        stall_if = 0; stall_id = 0;
        tick();
        n_vec++; if (o_pc !== 64'h8000_0008) begin n_err++; $display("FAIL stall_release got %h want 80000008", o_pc); end
        instr_valid = 0;
        tick();
        arst = 1;
        tick();
        n_vec++; if ({f_addr, f_req, o_valid} !== {RST, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL reset_mid_miss got addr=%h req=%b v=%b want %h 0 0", f_addr, f_req, o_valid, RST);
        end
        arst = 0; instr_valid = 1;
        tick();
        n_vec++; if ({o_pc, o_valid} !== {RST, 1'b1}) begin
            n_err++; $display("FAIL reset_mid_miss_resume got pc=%h v=%b want %h 1", o_pc, o_valid, RST);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        trap = 1; trap_vec = 64'hffff_ffff_ffff_ffff; instr_valid = 1;
        tick();
        trap = 0;
        n_vec++; if (f_addr !== 64'hffff_ffff_ffff_fffc) begin n_err++; $display("FAIL wrap_align got %h want fffffffffffffffc", f_addr); end
        tick();
        n_vec++; if ({o_pc, o_pc4, f_addr} !== {64'hffff_ffff_ffff_fffc, 64'd0, 64'd0}) begin
            n_err++; $display("FAIL wrap_pc4 got pc=%h pc4=%h addr=%h want fffffffffffffffc 0 0", o_pc, o_pc4, f_addr);
        end
    endtask

    task automatic test_random();
        logic [292:0] got, exp;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            arst        = ($urandom_range(0, 199) == 0);
            stall_if    = ($urandom_range(0, 7) == 0);
            stall_id    = ($urandom_range(0, 7) == 0);
            flush_id    = ($urandom_range(0, 15) == 0);
            trap        = ($urandom_range(0, 31) == 0);
            mispred     = ($urandom_range(0, 15) == 0);
            trap_vec    = {$urandom, $urandom};
            pc_ex       = {$urandom, $urandom};
            btb_hit     = ($urandom_range(0, 3) == 0);
            pred_taken  = $urandom_range(0, 1) == 1;
            btb_tgt     = {$urandom, $urandom} & ~64'h3;
            btb_way     = 2'($urandom_range(0, 3));
            instr       = $urandom;
            instr_valid = ($urandom_range(0, 3) != 0);
            tick();
            got = {f_addr, f_req, o_instr, o_pc, o_pc4, o_pred, o_way, o_taken, o_valid};
            exp = {m_pc, !arst, m_instr, m_opc, m_opc4, m_pred, m_way, m_taken, m_valid};
            n_vec++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL random cycle %0d got %h want %h", i, got, exp);
            end
        end
        arst = 0;
    endtask

    initial begin
        idle_inputs();
        arst = 1;
        test_reset();
        test_seq_hits();
        test_btb();
        test_miss();
        test_drain();
        test_trap_flush();
        test_stall_and_reset_mid_miss();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage plus IF/ID pipeline register, directly upstream of decode_stage. Holds the PC and selects next-PC (trap vector, mispredict redirect, BTB prediction, PC+4). Issues fetch addresses to the instruction cache and handles misses with a small FSM. Registers instruction, PC, PC+4 and prediction metadata for decode, with stall and flush control.

Parameters:
ADDR_WIDTH, 64, PC/address width
INSTR_WIDTH, 32, instruction width
RESET_PC, 64'h0000_0000_8000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
i_clk  in  1  clock
i_arst  in  1  reset, synchronous, active-high
i_stall_if  in  1  hold PC (hazard unit)
i_stall_id  in  1  hold IF/ID register
i_flush_id  in  1  load bubble into IF/ID
i_trap_redirect  in  1  trap/ecall redirect request
i_trap_vector  in  ADDR_WIDTH  trap target
i_branch_mispred  in  1  execute-stage mispredict redirect
i_pc_target_ex  in  ADDR_WIDTH  corrected PC from execute
i_btb_hit  in  1  BTB hit for current PC
i_btb_target  in  ADDR_WIDTH  BTB predicted target
i_btb_way  in  2  BTB way of hit
i_pred_taken  in  1  direction predictor: taken
i_instr  in  INSTR_WIDTH  I-cache read data
i_instr_valid  in  1  I-cache hit/fill complete this cycle
o_fetch_addr  out  ADDR_WIDTH  I-cache address
o_fetch_req  out  1  I-cache request
o_instruction  out  INSTR_WIDTH  IF/ID instruction
o_pc  out  ADDR_WIDTH  IF/ID PC
o_pc_plus4  out  ADDR_WIDTH  IF/ID PC+4
o_pc_target_addr_pred  out  ADDR_WIDTH  IF/ID predicted next PC
o_btb_way  out  2  IF/ID BTB way
o_branch_pred_taken  out  1  IF/ID predicted taken
o_valid  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (i_arst high at a clock edge, overrides everything, including mid-miss): PC=RESET_PC, FSM=FETCH, pending regs 0; IF/ID = bubble (o_instruction=NOP_INSTR, o_valid=0, o_pc=0, o_pc_plus4=0, o_pc_target_addr_pred=0, o_btb_way=0, o_branch_pred_taken=0). o_fetch_req=0 only while in reset.
- Redirect priority: i_trap_redirect > i_branch_mispred > (i_btb_hit & i_pred_taken → i_btb_target) > PC+4. Redirect target bits[1:0] forced to 0. PC+4 wraps modulo 2^ADDR_WIDTH.
- Predicted next PC (to IF/ID) = i_btb_target if i_btb_hit & i_pred_taken, else PC+4; o_branch_pred_taken = i_btb_hit & i_pred_taken.
- FSM FETCH: o_fetch_addr=PC, o_fetch_req=1.
  - redirect: PC<=target next cycle regardless of i_stall_if; IF/ID loads bubble (unless i_stall_id and not i_flush_id).
  - i_instr_valid & !i_stall_if: PC<=predicted next PC; IF/ID loads instr (if !i_stall_id).
  - !i_instr_valid, no redirect: →MISS_WAIT, PC held; IF/ID loads bubble if !i_stall_id.
  - i_stall_if: PC held, no IF/ID load of this fetch.
- FSM MISS_WAIT: o_fetch_addr=PC held, o_fetch_req=1. On i_instr_valid: behave as FETCH hit (load IF/ID, advance PC) →FETCH. Redirect arriving here: store target in pending reg →DRAIN.
- FSM DRAIN: o_fetch_addr held at missed PC (fill must finish); wait for i_instr_valid, discard data, PC<=pending →FETCH. A newer redirect in DRAIN overwrites pending (trap priority still applies).
- IF/ID: latency 1 cycle from hit to decode. i_flush_id > i_stall_id > load. Flush loads bubble. Stall holds all IF/ID fields.
- Bubble inserted whenever no valid instruction is captured; decode never sees a stale instruction twice unless i_stall_id.

Test Plan:
- Reset then 3 hits, no predict → o_pc 0x80000000, 0x80000004, 0x80000008 on successive cycles, o_valid=1, first valid output 1 cycle after first hit.
- BTB hit+taken at 0x80000004, target 0x80000100 → next fetch 0x80000100; IF/ID o_pc_target_addr_pred=0x80000100, o_branch_pred_taken=1.
- Miss at 0x80000008 for 4 cycles → o_fetch_addr held, o_valid=0 for 4 cycles, then instr with o_pc=0x80000008.
- Mispredict to 0x80000200 during MISS_WAIT → DRAIN; fill data discarded (o_valid stays 0); next fetch 0x80000200.
- Trap (vector 0x80001000) and mispredict same cycle, plus i_flush_id → PC=0x80001000, IF/ID bubble.
- i_stall_id for 2 cycles with i_stall_if → IF/ID and PC unchanged; reset asserted mid-miss → PC=RESET_PC, FSM FETCH, bubble.
